// File: rtl/risc_ctrl_pkg.sv
// Shared definitions for the 16-bit RISC multi-cycle controller.
// Holds the opcode/op field codes, the register-select and writeback-source
// codes, and the controller state enumeration.
package risc_ctrl_pkg;

  // opcode field
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // op field for ALU instructions
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  // op field for MOV instructions
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  // register select (nsel)
  localparam logic [1:0] RN = 2'b00;
  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] RM = 2'b10;

  // writeback source (vsel)
  localparam logic [1:0] VS_C     = 2'b00;
  localparam logic [1:0] VS_IMM8  = 2'b01;
  localparam logic [1:0] VS_MDATA = 2'b10;
  localparam logic [1:0] VS_PC    = 2'b11;

  typedef enum logic [4:0] {
    RST,
    IF1,
    UPDPC,
    DECODE,
    WR_IMM,
    GET_A,
    GET_B,
    GET_BD,
    EXEC,
    PASS_B,
    ADDR,
    MRD,
    MWR,
    WR_RD,
    WR_MEM,
    HALT,
    FAULT
  } state_t;

endpackage

// File: rtl/risc_wait_timer.sv
// Wait-state timer for memory accesses.
// Counts cycles spent waiting for memory and flags when the wait budget is
// exhausted. The count saturates at WAIT_MAX and never wraps.
// Ports:
//   clk     in  rising-edge clock
//   reset   in  asynchronous active-high reset (count -> 0)
//   clear   in  restart the count at 0 (has priority over inc)
//   inc     in  one more cycle spent waiting
//   expired out count has reached WAIT_MAX
module risc_wait_timer #(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_W'(WAIT_MAX);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CNT_MAX);

endmodule

// File: rtl/risc_ctrl_fsm.sv
// Multi-cycle control FSM for the 16-bit RISC core.
// Sequences fetch / PC update / decode / execute for MOV, ALU, LDR and STR,
// with a memory ready handshake and a bounded wait timer. A memory access
// that waits too long lands in a sticky FAULT state left only by reset.
//
// Build option: define RISC_CTRL_HALT_EN to make opcode 111 enter a sticky
// HALT state; otherwise 111 behaves like any undefined opcode (no-op).
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   opcode, op              decoded instruction fields from the IR
//   mem_ready               memory finishes the current mread/mwrite
//   nsel, vsel              register select, writeback source
//   loada..write            datapath load/select/write controls
//   loadir, loadpc,
//   reset_pc, msel          IR load, PC load, PC clear, address select
//   mread, mwrite           memory strobes, held until mem_ready
//   halted, mem_err         halted (HALT or FAULT), sticky memory fault
module risc_ctrl_fsm
  import risc_ctrl_pkg::*;
#(
  parameter int OPC_W    = 3,
  parameter int OP_W     = 2,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic [1:0]       nsel,
  output logic [1:0]       vsel,
  output logic             loada,
  output logic             loadb,
  output logic             asel,
  output logic             bsel,
  output logic             loadc,
  output logic             loads,
  output logic             write,
  output logic             loadir,
  output logic             loadpc,
  output logic             reset_pc,
  output logic             msel,
  output logic             mread,
  output logic             mwrite,
  output logic             halted,
  output logic             mem_err
);

  state_t state, state_nx;
  logic   wait_st;
  logic   expired;
  logic   is_mem_op;
  logic   is_cmp;

  assign is_mem_op = (opcode == OPC_W'(OPC_LDR)) || (opcode == OPC_W'(OPC_STR));
  assign is_cmp    = (opcode == OPC_W'(OPC_ALU)) && (op == OP_W'(OP_CMP));

  // The timer runs only in the three states that wait on memory. Leaving a
  // wait state always goes through a ready cycle or a non-wait state, so
  // clearing on either restarts the count for the next access.
  assign wait_st = (state == IF1) || (state == MRD) || (state == MWR);

  risc_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!wait_st || mem_ready),
    .inc     (wait_st && !mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RST;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      RST:    state_nx = IF1;
      // ready wins over an expiring timer in the same cycle
      IF1: begin
        if (mem_ready)    state_nx = UPDPC;
        else if (expired) state_nx = FAULT;
      end
      UPDPC:  state_nx = DECODE;
      DECODE: begin
        case (opcode)
          OPC_W'(OPC_MOV): state_nx = (op == OP_W'(OP_MOV_IMM)) ? WR_IMM : GET_B;
          OPC_W'(OPC_ALU): state_nx = (op == OP_W'(OP_MVN)) ? GET_B : GET_A;
          OPC_W'(OPC_LDR): state_nx = GET_A;
          OPC_W'(OPC_STR): state_nx = GET_A;
`ifdef RISC_CTRL_HALT_EN
          OPC_W'(OPC_HALT): state_nx = HALT;
`endif
          default:         state_nx = IF1;
        endcase
      end
      WR_IMM: state_nx = IF1;
      GET_A:  state_nx = is_mem_op ? ADDR : GET_B;
      GET_B:  state_nx = EXEC;
      EXEC:   state_nx = is_cmp ? IF1 : WR_RD;
      WR_RD:  state_nx = IF1;
      ADDR:   state_nx = (opcode == OPC_W'(OPC_LDR)) ? MRD : GET_BD;
      MRD: begin
        if (mem_ready)    state_nx = WR_MEM;
        else if (expired) state_nx = FAULT;
      end
      WR_MEM: state_nx = IF1;
      GET_BD: state_nx = PASS_B;
      PASS_B: state_nx = MWR;
      MWR: begin
        if (mem_ready)    state_nx = IF1;
        else if (expired) state_nx = FAULT;
      end
      HALT:   state_nx = HALT;
      FAULT:  state_nx = FAULT;
      default: state_nx = RST;
    endcase
  end

  // Output decode. EXEC also looks at the instruction fields, which the IR
  // holds stable for the whole instruction.
  always_comb begin
    nsel     = RN;
    vsel     = VS_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    loadir   = 1'b0;
    loadpc   = 1'b0;
    reset_pc = 1'b0;
    msel     = 1'b0;
    mread    = 1'b0;
    mwrite   = 1'b0;
    halted   = 1'b0;
    mem_err  = 1'b0;
    case (state)
      RST: reset_pc = 1'b1;
      // IR reloads on every waiting cycle; the load made when memory is
      // ready is the one that sticks.
      IF1: begin
        loadir = 1'b1;
        mread  = 1'b1;
      end
      UPDPC: loadpc = 1'b1;
      WR_IMM: begin
        nsel  = RN;
        vsel  = VS_IMM8;
        write = 1'b1;
      end
      GET_A: begin
        nsel  = RN;
        loada = 1'b1;
      end
      GET_B: begin
        nsel  = RM;
        loadb = 1'b1;
      end
      EXEC: begin
        asel  = (opcode == OPC_W'(OPC_MOV));
        loadc = 1'b1;
        loads = is_cmp;
      end
      WR_RD: begin
        nsel  = RD;
        vsel  = VS_C;
        write = 1'b1;
      end
      ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      MRD: begin
        msel  = 1'b1;
        mread = 1'b1;
      end
      WR_MEM: begin
        nsel  = RD;
        vsel  = VS_MDATA;
        write = 1'b1;
      end
      GET_BD: begin
        nsel  = RD;
        loadb = 1'b1;
      end
      // address comes from an external latch, so msel is already 1 here
      PASS_B: begin
        asel  = 1'b1;
        loadc = 1'b1;
        msel  = 1'b1;
      end
      MWR: begin
        msel   = 1'b1;
        mwrite = 1'b1;
      end
      HALT: halted = 1'b1;
      FAULT: begin
        halted  = 1'b1;
        mem_err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Scoreboard bench for risc_ctrl_fsm: expected control words and the
// mem_ready value for each cycle are queued when an instruction is set up,
// then popped and compared one per clock.
module tb_risc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       mem_ready;
  logic [1:0] nsel, vsel;
  logic loada, loadb, asel, bsel, loadc, loads, write;
  logic loadir, loadpc, reset_pc, msel, mread, mwrite, halted, mem_err;

  risc_ctrl_fsm #(
    .OPC_W    (3),
    .OP_W     (2),
    .WAIT_MAX (15),
    .WAIT_W   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .op        (op),
    .mem_ready (mem_ready),
    .nsel      (nsel),
    .vsel      (vsel),
    .loada     (loada),
    .loadb     (loadb),
    .asel      (asel),
    .bsel      (bsel),
    .loadc     (loadc),
    .loads     (loads),
    .write     (write),
    .loadir    (loadir),
    .loadpc    (loadpc),
    .reset_pc  (reset_pc),
    .msel      (msel),
    .mread     (mread),
    .mwrite    (mwrite),
    .halted    (halted),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  // {nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write,
  //  loadir, loadpc, reset_pc, msel, mread, mwrite, halted, mem_err}
  logic [18:0] ctl;
  assign ctl = {nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write,
                loadir, loadpc, reset_pc, msel, mread, mwrite, halted, mem_err};

  // expected control words per state, built by hand from the bit layout
  localparam logic [18:0] W_RST    = 19'h00020;  // reset_pc
  localparam logic [18:0] W_IF1    = 19'h00088;  // loadir, mread, msel=0
  localparam logic [18:0] W_UPDPC  = 19'h00040;  // loadpc
  localparam logic [18:0] W_DECODE = 19'h00000;
  localparam logic [18:0] W_WRIMM  = 19'h08100;  // nsel Rn, vsel imm8, write
  localparam logic [18:0] W_GETA   = 19'h04000;  // nsel Rn, loada
  localparam logic [18:0] W_GETB   = 19'h42000;  // nsel Rm, loadb
  localparam logic [18:0] W_EXALU  = 19'h00400;  // loadc
  localparam logic [18:0] W_EXCMP  = 19'h00600;  // loadc, loads
  localparam logic [18:0] W_EXMOV  = 19'h01400;  // asel, loadc
  localparam logic [18:0] W_WRRD   = 19'h20100;  // nsel Rd, vsel C, write
  localparam logic [18:0] W_ADDR   = 19'h00C00;  // bsel, loadc
  localparam logic [18:0] W_MRD    = 19'h00018;  // msel, mread
  localparam logic [18:0] W_WRMEM  = 19'h30100;  // nsel Rd, vsel mdata, write
  localparam logic [18:0] W_GETBD  = 19'h22000;  // nsel Rd, loadb
  localparam logic [18:0] W_PASSB  = 19'h01410;  // asel, loadc, msel
  localparam logic [18:0] W_MWR    = 19'h00014;  // msel, mwrite
  localparam logic [18:0] W_HALT   = 19'h00002;  // halted
  localparam logic [18:0] W_FAULT  = 19'h00003;  // halted, mem_err

  typedef struct {
    string       tag;
    logic [18:0] w;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input string tag, input logic [18:0] w, input logic rdy);
    exp_t e;
    e.tag = tag;
    e.w   = w;
    e.rdy = rdy;
    exp_q.push_back(e);
  endtask

  // called at a negedge; each entry covers one clock cycle
  task automatic run_q();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mem_ready = e.rdy;
      #1;
      chk(e.tag, ctl, e.w);
      @(negedge clk);
    end
  endtask

  task automatic push_fetch(input string pfx);
    push({pfx, "_if1"},    W_IF1,    1'b1);
    push({pfx, "_updpc"},  W_UPDPC,  1'b1);
    push({pfx, "_decode"}, W_DECODE, 1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 3'b110;
    op        = 2'b10;
    #1;
    chk("reset_async", ctl, W_RST);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // MOV immediate: RST IF1 UPDPC DECODE WR_IMM
    push("mov_rst", W_RST, 1'b1);
    push_fetch("movi");
    push("movi_wrimm", W_WRIMM, 1'b1);
    run_q();

    // CMP: IF1 UPDPC DECODE GET_A GET_B EXEC, no write
    opcode = 3'b101; op = 2'b01;
    push_fetch("cmp");
    push("cmp_geta", W_GETA, 1'b1);
    push("cmp_getb", W_GETB, 1'b1);
    push("cmp_exec", W_EXCMP, 1'b1);
    run_q();

    // ADD
    opcode = 3'b101; op = 2'b00;
    push_fetch("add");
    push("add_geta", W_GETA, 1'b1);
    push("add_getb", W_GETB, 1'b1);
    push("add_exec", W_EXALU, 1'b1);
    push("add_wrrd", W_WRRD, 1'b1);
    run_q();

    // MVN skips GET_A
    opcode = 3'b101; op = 2'b11;
    push_fetch("mvn");
    push("mvn_getb", W_GETB, 1'b1);
    push("mvn_exec", W_EXALU, 1'b1);
    push("mvn_wrrd", W_WRRD, 1'b1);
    run_q();

    // MOV register
    opcode = 3'b110; op = 2'b00;
    push_fetch("movr");
    push("movr_getb", W_GETB, 1'b1);
    push("movr_exec", W_EXMOV, 1'b1);
    push("movr_wrrd", W_WRRD, 1'b1);
    run_q();

    // LDR with three not-ready cycles in MRD: mread held 4 cycles
    opcode = 3'b011; op = 2'b00;
    push_fetch("ldr");
    push("ldr_geta", W_GETA, 1'b1);
    push("ldr_addr", W_ADDR, 1'b1);
    push("ldr_mrd0", W_MRD, 1'b0);
    push("ldr_mrd1", W_MRD, 1'b0);
    push("ldr_mrd2", W_MRD, 1'b0);
    push("ldr_mrd3", W_MRD, 1'b1);
    push("ldr_wrmem", W_WRMEM, 1'b1);
    run_q();

    // STR with one not-ready cycle in MWR
    opcode = 3'b100; op = 2'b00;
    push_fetch("str");
    push("str_geta", W_GETA, 1'b1);
    push("str_addr", W_ADDR, 1'b1);
    push("str_getbd", W_GETBD, 1'b1);
    push("str_passb", W_PASSB, 1'b1);
    push("str_mwr0", W_MWR, 1'b0);
    push("str_mwr1", W_MWR, 1'b1);
    run_q();

    // fetch waits 15 cycles, ready arrives as the count hits 15: ready wins;
    // undefined opcode 000 then returns straight to IF1
    opcode = 3'b000; op = 2'b00;
    for (int i = 0; i < 15; i++) push("edge_if1_wait", W_IF1, 1'b0);
    push("edge_if1_rdy", W_IF1, 1'b1);
    push("edge_updpc", W_UPDPC, 1'b1);
    push("edge_decode", W_DECODE, 1'b1);
    run_q();

    // opcode 111
    opcode = 3'b111; op = 2'b00;
    push_fetch("op111");
`ifdef RISC_CTRL_HALT_EN
    for (int i = 0; i < 20; i++) push("halt_hold", W_HALT, 1'b1);
    run_q();
    reset = 1'b1;
    #1;
    chk("halt_reset", ctl, W_RST);
    @(negedge clk);
    reset = 1'b0;
    push("halt_rst", W_RST, 1'b1);
`endif
    run_q();

    // ADD up to EXEC, then reset asynchronously mid-cycle
    opcode = 3'b101; op = 2'b00;
    push_fetch("abort");
    push("abort_geta", W_GETA, 1'b1);
    push("abort_getb", W_GETB, 1'b1);
    run_q();
    #1;
    chk("abort_exec", ctl, W_EXALU);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_reset", ctl, W_RST);
    @(negedge clk);
    reset = 1'b0;
    push("abort_rst", W_RST, 1'b1);
    run_q();

    // fetch never ready: 16 cycles in IF1 (counts 0..15), then sticky FAULT
    for (int i = 0; i < 16; i++) push("fault_if1", W_IF1, 1'b0);
    for (int i = 0; i < 4; i++) push("fault_hold", W_FAULT, 1'b1);
    run_q();
    reset = 1'b1;
    #1;
    chk("fault_reset", ctl, W_RST);
    @(negedge clk);
    reset = 1'b0;
    opcode = 3'b110; op = 2'b10;
    push("post_rst", W_RST, 1'b1);
    push_fetch("post");
    push("post_wrimm", W_WRIMM, 1'b1);
    push("post_if1", W_IF1, 1'b1);
    run_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
